// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit
//   Selects each EX-stage ALU operand from EX/MEM, MEM/WB, a one-deep
//   WB-history bypass register or the register file. Also detects load-use
//   hazards between ID and EX and holds stall/flush_idex for LOAD_LAT cycles.
//   Build macro FWD_STATS_EN adds saturating stall/forward event counters
//   (stat_stall_cnt, stat_fwd_cnt). Without it, those ports do not exist.
//   Reset is synchronous and active-high (rst).

module forwarding_hazard_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  // EX stage operand sources
  input  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] ex_reg_data,
  input  logic [ADDR_W-1:0]         ex_mem_rd,
  input  logic                      ex_mem_wen,
  input  logic [DATA_W-1:0]         ex_mem_data,
  input  logic [ADDR_W-1:0]         mem_wb_rd,
  input  logic                      mem_wb_wen,
  input  logic [DATA_W-1:0]         mem_wb_data,
  // ID stage reads and the instruction currently in EX
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_valid,
  input  logic [ADDR_W-1:0]         idex_rd,
  input  logic                      idex_wen,
  input  logic                      idex_is_load,
  // Results
  output logic [NUM_SRC*DATA_W-1:0] ex_operand,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      flush_idex
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]               stat_stall_cnt,
  output logic [31:0]               stat_fwd_cnt
`endif
);

  // Per-operand source select encoding seen on fwd_sel.
  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_MEMWB = 2'b01,
    SEL_EXMEM = 2'b10,
    SEL_HIST  = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // The hazard cycle itself is the first stall cycle, so STALL covers the
  // remaining LOAD_LAT-1 cycles; cnt counts down to zero from LOAD_LAT-2.
  localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  // --------------------------------------------------------------------------
  // WB-history bypass register
  // --------------------------------------------------------------------------
  logic              hist_valid_q, hist_valid_d;
  logic [ADDR_W-1:0] hist_rd_q,    hist_rd_d;
  logic [DATA_W-1:0] hist_data_q,  hist_data_d;
  logic              hist_valid_eff;

  // Capture every MEM/WB writeback so a register file without write-through
  // can still be bypassed one cycle later.
  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so
    // no latch can be inferred.
    hist_valid_d = mem_wb_wen && (mem_wb_rd != '0);
    hist_rd_d    = mem_wb_rd;
    hist_data_d  = mem_wb_data;
    if (rst) begin
      hist_valid_d = 1'b0;
      hist_rd_d    = '0;
      hist_data_d  = '0;
    end
  end

  // History flops; reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so all flops sample pre-edge values.
    hist_valid_q <= hist_valid_d;
    hist_rd_q    <= hist_rd_d;
    hist_data_q  <= hist_data_d;
  end

  // While rst is high the bypass is treated as empty even before the edge
  // that clears it.
  assign hist_valid_eff = hist_valid_q && !rst;

  // --------------------------------------------------------------------------
  // Operand forwarding (combinational, zero latency)
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_op
    logic [ADDR_W-1:0] src;
    logic              src_nonzero;
    logic              hit_exmem;
    logic              hit_memwb;
    logic              hit_hist;
    fwd_sel_e          sel;
    logic [DATA_W-1:0] operand;

    assign src         = ex_src_addr[g*ADDR_W +: ADDR_W];
    // x0 is hard-wired zero and must never be forwarded; because a hit also
    // needs rd==src, this single term excludes rd==0 as well.
    assign src_nonzero = (src != '0);
    assign hit_exmem   = src_nonzero && ex_mem_wen     && (ex_mem_rd == src);
    assign hit_memwb   = src_nonzero && mem_wb_wen     && (mem_wb_rd == src);
    assign hit_hist    = src_nonzero && hist_valid_eff && (hist_rd_q == src);

    // Youngest producer wins: EX/MEM, then MEM/WB, then history, then regfile.
    always_comb begin
      sel     = SEL_RF;
      operand = ex_reg_data[g*DATA_W +: DATA_W];
      if (hit_exmem) begin
        sel     = SEL_EXMEM;
        operand = ex_mem_data;
      end else if (hit_memwb) begin
        sel     = SEL_MEMWB;
        operand = mem_wb_data;
      end else if (hit_hist) begin
        sel     = SEL_HIST;
        operand = hist_data_q;
      end
    end

    assign fwd_sel[2*g +: 2]              = sel;
    assign ex_operand[g*DATA_W +: DATA_W] = operand;
  end

  // --------------------------------------------------------------------------
  // Load-use hazard detection
  // --------------------------------------------------------------------------
  logic [NUM_SRC-1:0] id_hit;
  logic               load_in_ex;
  logic               hazard;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_haz
    assign id_hit[g] = id_src_valid[g] && (id_src_addr[g*ADDR_W +: ADDR_W] == idex_rd);
  end

  assign load_in_ex = idex_is_load && idex_wen && (idex_rd != '0);
  assign hazard     = load_in_ex && (|id_hit);

  // --------------------------------------------------------------------------
  // Stall / flush FSM
  // --------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [1:0] cnt_q,   cnt_d;
  logic       stall_int;

  // Next-state and stall decode. The IDLE-cycle stall follows hazard directly
  // so the very cycle the hazard is seen is already frozen.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_int = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_int = hazard;
        // With LOAD_LAT==1 the bubble inserted now clears the hazard by
        // itself, so there is nothing left to count.
        if (hazard && (LOAD_LAT > 1)) begin
          state_d = ST_STALL;
          cnt_d   = CNT_INIT;
        end
      end
      ST_STALL: begin
        // The bubble already in EX may no longer show the load, so hazard
        // is deliberately ignored while counting down.
        stall_int = 1'b1;
        if (cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
    // Reset aborts any stall sequence immediately and masks the outputs.
    if (rst) begin
      state_d   = ST_IDLE;
      cnt_d     = 2'd0;
      stall_int = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign stall      = stall_int;
  assign flush_idex = stall_int;

`ifdef FWD_STATS_EN
  // --------------------------------------------------------------------------
  // Event counters
  // --------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q,   fwd_cnt_d;
  logic        any_fwd;

  assign any_fwd = |fwd_sel;

  // Saturating increments; clearing on rst takes precedence.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (any_fwd && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
    if (rst) begin
      stall_cnt_d = '0;
      fwd_cnt_d   = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    fwd_cnt_q   <= fwd_cnt_d;
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit
//   Three instances (LOAD_LAT = 1, 2, 3) share one stimulus stream. A
//   reference model built from the forwarding priority list and a
//   "remaining stall cycles" count predicts every output each cycle.
//   Stat counters are checked only when FWD_STATS_EN is defined.

module tb_forwarding_hazard_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic              rst;
  logic [NS*AW-1:0]  ex_src_addr;
  logic [NS*DW-1:0]  ex_reg_data;
  logic [AW-1:0]     ex_mem_rd;
  logic              ex_mem_wen;
  logic [DW-1:0]     ex_mem_data;
  logic [AW-1:0]     mem_wb_rd;
  logic              mem_wb_wen;
  logic [DW-1:0]     mem_wb_data;
  logic [NS*AW-1:0]  id_src_addr;
  logic [NS-1:0]     id_src_valid;
  logic [AW-1:0]     idex_rd;
  logic              idex_wen;
  logic              idex_is_load;

  // Per-instance outputs, indexed by LOAD_LAT
  logic [NS*DW-1:0]  operand_o [1:3];
  logic [2*NS-1:0]   sel_o     [1:3];
  logic              stall_o   [1:3];
  logic              flush_o   [1:3];
`ifdef FWD_STATS_EN
  logic [31:0]       stat_stall_o [1:3];
  logic [31:0]       stat_fwd_o   [1:3];
`endif

  for (genvar k = 1; k <= 3; k++) begin : g_dut
    forwarding_hazard_unit #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .NUM_SRC (NS),
      .LOAD_LAT(k)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .ex_src_addr  (ex_src_addr),
      .ex_reg_data  (ex_reg_data),
      .ex_mem_rd    (ex_mem_rd),
      .ex_mem_wen   (ex_mem_wen),
      .ex_mem_data  (ex_mem_data),
      .mem_wb_rd    (mem_wb_rd),
      .mem_wb_wen   (mem_wb_wen),
      .mem_wb_data  (mem_wb_data),
      .id_src_addr  (id_src_addr),
      .id_src_valid (id_src_valid),
      .idex_rd      (idex_rd),
      .idex_wen     (idex_wen),
      .idex_is_load (idex_is_load),
      .ex_operand   (operand_o[k]),
      .fwd_sel      (sel_o[k]),
      .stall        (stall_o[k]),
      .flush_idex   (flush_o[k])
`ifdef FWD_STATS_EN
      ,
      .stat_stall_cnt(stat_stall_o[k]),
      .stat_fwd_cnt  (stat_fwd_o[k])
`endif
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int               rem [1:3];          // forced stall cycles still owed
  logic             m_hist_valid;
  logic [AW-1:0]    m_hist_rd;
  logic [DW-1:0]    m_hist_data;
  longint           m_stall_cnt [1:3];
  longint           m_fwd_cnt;

  // Expected values for the current cycle
  logic [2*NS-1:0]  exp_sel;
  logic [NS*DW-1:0] exp_op;
  logic             exp_hazard;
  logic             exp_stall [1:3];

  // Forwarding: scan the producers youngest-first, first address match wins.
  task automatic compute_expected();
    logic          cand_ok   [3];
    logic [AW-1:0] cand_rd   [3];
    logic [DW-1:0] cand_data [3];
    logic [1:0]    cand_code [3];
    cand_ok[0] = ex_mem_wen;            cand_rd[0] = ex_mem_rd;
    cand_data[0] = ex_mem_data;         cand_code[0] = 2'b10;
    cand_ok[1] = mem_wb_wen;            cand_rd[1] = mem_wb_rd;
    cand_data[1] = mem_wb_data;         cand_code[1] = 2'b01;
    cand_ok[2] = m_hist_valid && !rst;  cand_rd[2] = m_hist_rd;
    cand_data[2] = m_hist_data;         cand_code[2] = 2'b11;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] s;
      logic [1:0]    code;
      logic [DW-1:0] val;
      logic          found;
      s     = ex_src_addr[i*AW +: AW];
      code  = 2'b00;
      val   = ex_reg_data[i*DW +: DW];
      found = 1'b0;
      if (s != 0) begin
        for (int c = 0; c < 3; c++) begin
          if (!found && cand_ok[c] && cand_rd[c] == s) begin
            found = 1'b1;
            code  = cand_code[c];
            val   = cand_data[c];
          end
        end
      end
      exp_sel[2*i +: 2]  = code;
      exp_op[i*DW +: DW] = val;
    end
    exp_hazard = 1'b0;
    if (idex_is_load && idex_wen && idex_rd != 0) begin
      for (int i = 0; i < NS; i++) begin
        if (id_src_valid[i] && id_src_addr[i*AW +: AW] == idex_rd) exp_hazard = 1'b1;
      end
    end
    for (int k = 1; k <= 3; k++) begin
      exp_stall[k] = rst ? 1'b0 : (rem[k] > 0 || exp_hazard);
    end
  endtask

  // Called at the negative edge once inputs are set: compare, clock, advance.
  task automatic run_cycle();
    #1;
    compute_expected();
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("sel%0d", k),   sel_o[k],     exp_sel);
      check($sformatf("op%0d", k),    operand_o[k], exp_op);
      check($sformatf("stall%0d", k), stall_o[k],   exp_stall[k]);
      check($sformatf("flush%0d", k), flush_o[k],   exp_stall[k]);
`ifdef FWD_STATS_EN
      check($sformatf("stat_stall%0d", k), stat_stall_o[k], m_stall_cnt[k]);
      check($sformatf("stat_fwd%0d", k),   stat_fwd_o[k],   m_fwd_cnt);
`endif
    end
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      if (rst)               rem[k] = 0;
      else if (rem[k] > 0)   rem[k] = rem[k] - 1;
      else if (exp_hazard)   rem[k] = k - 1;
      if (rst)               m_stall_cnt[k] = 0;
      else if (exp_stall[k]) m_stall_cnt[k] = (m_stall_cnt[k] >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall_cnt[k] + 1;
    end
    if (rst)               m_fwd_cnt = 0;
    else if (exp_sel != 0) m_fwd_cnt = (m_fwd_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_fwd_cnt + 1;
    if (rst) begin
      m_hist_valid = 1'b0;
      m_hist_rd    = '0;
      m_hist_data  = '0;
    end else begin
      m_hist_valid = mem_wb_wen && (mem_wb_rd != 0);
      m_hist_rd    = mem_wb_rd;
      m_hist_data  = mem_wb_data;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst          = 1'b0;
    ex_src_addr  = '0;
    ex_reg_data  = {32'h1111_0000, 32'h2222_0000};
    ex_mem_rd    = '0;
    ex_mem_wen   = 1'b0;
    ex_mem_data  = '0;
    mem_wb_rd    = '0;
    mem_wb_wen   = 1'b0;
    mem_wb_data  = '0;
    id_src_addr  = '0;
    id_src_valid = '0;
    idex_rd      = '0;
    idex_wen     = 1'b0;
    idex_is_load = 1'b0;
  endtask

  task automatic set_load_hazard(input logic [AW-1:0] rd);
    idex_rd      = rd;
    idex_wen     = 1'b1;
    idex_is_load = 1'b1;
    id_src_addr  = {5'd0, rd};
    id_src_valid = 2'b01;
  endtask

  initial begin
    for (int k = 1; k <= 3; k++) begin
      rem[k] = 0;
      m_stall_cnt[k] = 0;
    end
    m_fwd_cnt    = 0;
    m_hist_valid = 1'b0;
    m_hist_rd    = '0;
    m_hist_data  = '0;

    // Reset with a hazard and a writeback pending: outputs must stay quiet.
    clear_inputs();
    rst = 1'b1;
    set_load_hazard(5'd4);
    mem_wb_rd = 5'd9; mem_wb_wen = 1'b1; mem_wb_data = 32'h5555;
    @(negedge clk);
    #1 check("rst_stall", stall_o[3], 1'b0);
    run_cycle();
    run_cycle();
    clear_inputs();
    ex_src_addr = {5'd0, 5'd9};
    #1 check("rst_hist_sel", sel_o[1][1:0], 2'b00);
    run_cycle();

    // EX/MEM beats MEM/WB for the same register.
    clear_inputs();
    ex_src_addr = {5'd0, 5'd5};
    ex_mem_rd = 5'd5; ex_mem_wen = 1'b1; ex_mem_data = 32'hAAAA_0001;
    mem_wb_rd = 5'd5; mem_wb_wen = 1'b1; mem_wb_data = 32'hBBBB_0002;
    #1;
    check("tp_exmem_sel", sel_o[1][1:0], 2'b10);
    check("tp_exmem_op", operand_o[1][31:0], 32'hAAAA_0001);
    run_cycle();

    // Register 0 is never forwarded.
    clear_inputs();
    ex_mem_rd = 5'd0; ex_mem_wen = 1'b1; ex_mem_data = 32'h1234;
    #1;
    check("tp_r0_sel", sel_o[1][1:0], 2'b00);
    check("tp_r0_op", operand_o[1][31:0], 32'h2222_0000);
    run_cycle();

    // WB-history bypass: writeback of r7, read it one cycle later.
    clear_inputs();
    ex_src_addr = {5'd0, 5'd1};
    mem_wb_rd = 5'd7; mem_wb_wen = 1'b1; mem_wb_data = 32'hCAFE;
    run_cycle();
    clear_inputs();
    ex_src_addr = {5'd0, 5'd7};
    #1;
    check("tp_hist_sel", sel_o[2][1:0], 2'b11);
    check("tp_hist_op", operand_o[2][31:0], 32'hCAFE);
    run_cycle();
    #1 check("tp_hist_gone", sel_o[2][1:0], 2'b00);
    run_cycle();

    // Load-use hazard: LOAD_LAT=2 stalls exactly two cycles.
    clear_inputs();
    set_load_hazard(5'd3);
    #1;
    check("tp_ll2_c0", stall_o[2], 1'b1);
    check("tp_ll2_f0", flush_o[2], 1'b1);
    run_cycle();
    #1 check("tp_ll2_c1", stall_o[2], 1'b1);
    run_cycle();
    clear_inputs();
    #1 check("tp_ll2_c2", stall_o[2], 1'b0);
    run_cycle();
    run_cycle();

    // No hazard when the matching operand is not read, or when rd is x0.
    clear_inputs();
    set_load_hazard(5'd3);
    id_src_valid = 2'b00;
    #1 check("tp_novalid", stall_o[1], 1'b0);
    run_cycle();
    set_load_hazard(5'd0);
    #1 check("tp_rd0", stall_o[1], 1'b0);
    run_cycle();

    // LOAD_LAT=3: reset in the second stall cycle aborts the sequence.
    clear_inputs();
    set_load_hazard(5'd6);
    run_cycle();
    rst = 1'b1;
    #1 check("tp_ll3_rst", stall_o[3], 1'b0);
    run_cycle();
    clear_inputs();
    #1 check("tp_ll3_after", stall_o[3], 1'b0);
`ifdef FWD_STATS_EN
    check("tp_ll3_stat", stat_stall_o[3], 32'd0);
`endif
    run_cycle();

    // Randomized traffic over a small register window to force many matches.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      ex_mem_rd    = 5'($urandom_range(0, 3));
      ex_mem_wen   = 1'($urandom_range(0, 1));
      ex_mem_data  = $urandom;
      mem_wb_rd    = 5'($urandom_range(0, 3));
      mem_wb_wen   = 1'($urandom_range(0, 1));
      mem_wb_data  = $urandom;
      idex_rd      = 5'($urandom_range(0, 3));
      idex_wen     = 1'($urandom_range(0, 1));
      idex_is_load = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NS; i++) begin
        ex_src_addr[i*AW +: AW] = 5'($urandom_range(0, 3));
        ex_reg_data[i*DW +: DW] = $urandom;
        id_src_addr[i*AW +: AW] = 5'($urandom_range(0, 3));
        id_src_valid[i]         = 1'($urandom_range(0, 1));
      end
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
